// File: rtl/udp_ts_pkg.sv
// Shared encodings and default widths for the UDP TS transmit scheduler.
package udp_ts_pkg;

  localparam int unsigned DEF_POINTER_WIDTH = 2;
  localparam int unsigned DEF_CHANNELS      = 4;
  localparam int unsigned DEF_CHANNEL_BITS  = 2;

  // Arbiter states
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_REQ      = 2'd1;
  localparam logic [1:0] S_WAIT_REL = 2'd2;

  // Release sub-states
  localparam logic REL_IDLE     = 1'b0;
  localparam logic REL_WAIT_LOW = 1'b1;

endpackage

// File: rtl/udp_ts_ptr_fifo.sv
// Per-channel frame-pointer FIFO with registered full/empty flags.
module udp_ts_ptr_fifo
  import udp_ts_pkg::*;
#(
  parameter int unsigned P_POINTER_WIDTH   = DEF_POINTER_WIDTH,
  parameter int unsigned P_FIFO_DEPTH_LOG2 = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [P_POINTER_WIDTH-1:0] push_data,
  input  logic                       pop,
  output logic [P_POINTER_WIDTH-1:0] head,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned Depth = 2 ** P_FIFO_DEPTH_LOG2;

  logic [P_POINTER_WIDTH-1:0]   mem_q [Depth];
  logic [P_FIFO_DEPTH_LOG2-1:0] wr_q, rd_q;
  logic [P_FIFO_DEPTH_LOG2:0]   cnt_q, cnt_d;
  logic                         full_q, empty_q;
  logic                         do_push, do_pop;

  // Flags are registered, so a push into a full FIFO is dropped even if it pops this cycle.
  assign do_push = push & ~full_q;
  assign do_pop  = pop & ~empty_q;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == (P_FIFO_DEPTH_LOG2 + 1)'(Depth));
      empty_q <= (cnt_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end

  assign head  = mem_q[rd_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/udp_ts_tx_sched.sv
// Round-robin scheduler between per-channel frame FIFOs and the UDP TS transmit DMA,
// including the DMA release handshake and free-list return port.
module udp_ts_tx_sched
  import udp_ts_pkg::*;
#(
  parameter int unsigned P_POINTER_WIDTH   = DEF_POINTER_WIDTH,
  parameter int unsigned P_CHANNELS        = DEF_CHANNELS,
  parameter int unsigned P_CHANNEL_BITS    = DEF_CHANNEL_BITS,
  parameter int unsigned P_FIFO_DEPTH_LOG2 = 2,
  parameter int unsigned P_ACK_TIMEOUT     = 1023
) (
  input  logic                                  payload_clk,
  input  logic                                  payload_rst,
  input  logic [P_CHANNELS-1:0]                 sched_enable,
  input  logic [P_CHANNELS-1:0]                 ready_valid,
  input  logic [P_CHANNELS*P_POINTER_WIDTH-1:0] ready_pointer,
  output logic [P_CHANNELS-1:0]                 ready_full,
  output logic [P_CHANNELS-1:0]                 ovf_pulse,
  output logic                                  payload_out_req,
  output logic [P_POINTER_WIDTH-1:0]            payload_out_pointer,
  output logic [P_CHANNEL_BITS-1:0]             payload_out_channel,
  input  logic                                  payload_out_ack,
  input  logic                                  release_req,
  input  logic [P_POINTER_WIDTH-1:0]            release_pointer,
  output logic                                  release_ack,
  output logic                                  free_valid,
  output logic [P_POINTER_WIDTH-1:0]            free_pointer,
  input  logic                                  free_ready,
  output logic                                  timeout_err
);

  localparam int unsigned CntW = $clog2(P_ACK_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(P_ACK_TIMEOUT);

  logic [P_CHANNELS-1:0]      fifo_full, fifo_empty, pop, eligible;
  logic [P_POINTER_WIDTH-1:0] head [P_CHANNELS];

  for (genvar gi = 0; gi < P_CHANNELS; gi++) begin : g_fifo
    udp_ts_ptr_fifo #(
      .P_POINTER_WIDTH  (P_POINTER_WIDTH),
      .P_FIFO_DEPTH_LOG2(P_FIFO_DEPTH_LOG2)
    ) u_fifo (
      .clk      (payload_clk),
      .rst      (payload_rst),
      .push     (ready_valid[gi]),
      .push_data(ready_pointer[gi*P_POINTER_WIDTH +: P_POINTER_WIDTH]),
      .pop      (pop[gi]),
      .head     (head[gi]),
      .full     (fifo_full[gi]),
      .empty    (fifo_empty[gi])
    );
  end

  assign eligible = ~fifo_empty & sched_enable;

  // Returns {found, index}; walks from farthest to nearest so the channel right after last wins.
  function automatic logic [P_CHANNEL_BITS:0] rr_pick(input logic [P_CHANNELS-1:0] elig,
                                                      input logic [P_CHANNEL_BITS-1:0] last);
    logic [P_CHANNEL_BITS:0] res;
    int unsigned idx;
    res = '0;
    for (int unsigned k = P_CHANNELS; k >= 1; k--) begin
      idx = (k + int'(last)) % P_CHANNELS;
      if (elig[idx]) res = {1'b1, idx[P_CHANNEL_BITS-1:0]};
    end
    return res;
  endfunction

  // Arbiter
  logic [1:0]                 state_q, state_d;
  logic [P_CHANNEL_BITS-1:0]  rr_q, rr_d, ch_q, ch_d;
  logic [P_POINTER_WIDTH-1:0] ptr_q, ptr_d;
  logic                       req_q, req_d, to_q, to_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [P_CHANNEL_BITS:0]    pick;
  logic [P_CHANNEL_BITS-1:0]  pick_idx;
  logic                       rel_ack_q;

  assign pick     = rr_pick(eligible, rr_q);
  assign pick_idx = pick[P_CHANNEL_BITS-1:0];

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    pop     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (pick[P_CHANNEL_BITS]) begin
          pop[pick_idx] = 1'b1;
          ptr_d         = head[pick_idx];
          ch_d          = pick_idx;
          rr_d          = pick_idx;
          state_d       = S_REQ;
        end
      end
      S_REQ: begin
        if (req_q && payload_out_ack) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_WAIT_REL;
        end else begin
          // Timeout only reports; the request stays up until the DMA acks.
          req_d = 1'b1;
          if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 1'b1;
            to_d  = (cnt_q == CntMax - 1'b1);
          end
        end
      end
      S_WAIT_REL: begin
        if (rel_ack_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge payload_clk or posedge payload_rst) begin
    if (payload_rst) begin
      state_q <= S_IDLE;
      rr_q    <= P_CHANNEL_BITS'(P_CHANNELS - 1);
      ch_q    <= '0;
      ptr_q   <= '0;
      req_q   <= 1'b0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  // Release path, independent of the arbiter state
  logic                       rel_q, rel_d, rel_take;
  logic                       fv_q, fv_d;
  logic [P_POINTER_WIDTH-1:0] fp_q, fp_d;
  logic [P_CHANNELS-1:0]      ovf_q;

  assign rel_take = (rel_q == REL_IDLE) & release_req & (~fv_q | free_ready);

  always_comb begin
    rel_d = rel_q;
    fv_d  = fv_q;
    fp_d  = fp_q;
    if (rel_take) begin
      fv_d  = 1'b1;
      fp_d  = release_pointer;
      rel_d = REL_WAIT_LOW;
    end else if (fv_q && free_ready) begin
      fv_d = 1'b0;
    end
    if (rel_q == REL_WAIT_LOW && !release_req) rel_d = REL_IDLE;
  end

  always_ff @(posedge payload_clk or posedge payload_rst) begin
    if (payload_rst) begin
      rel_q     <= REL_IDLE;
      fv_q      <= 1'b0;
      fp_q      <= '0;
      rel_ack_q <= 1'b0;
      ovf_q     <= '0;
    end else begin
      rel_q     <= rel_d;
      fv_q      <= fv_d;
      fp_q      <= fp_d;
      rel_ack_q <= rel_take;
      ovf_q     <= ready_valid & fifo_full;
    end
  end

  assign ready_full          = fifo_full;
  assign ovf_pulse           = ovf_q;
  assign payload_out_req     = req_q;
  assign payload_out_pointer = ptr_q;
  assign payload_out_channel = ch_q;
  assign release_ack         = rel_ack_q;
  assign free_valid          = fv_q;
  assign free_pointer        = fp_q;
  assign timeout_err         = to_q;

endmodule
